// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the pipelined MIPS core.
// Owns the fetch PC, issues in-order requests to instruction memory under a
// credit limit of BUF_DEPTH (outstanding + buffered), buffers responses in a
// small FIFO and presents one instruction per cycle to decode on the IF->ID
// interface. Redirects come from decode (J/JAL) and EX (taken branches);
// responses already in flight at a redirect are counted and discarded.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        AnyStall,
    input  logic        Jump_IDM1,
    input  logic [25:0] JumpTgt_IDM1,
    input  logic        ExRedirect_EX,
    input  logic [31:0] ExRedirectPc_EX,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRspVal,
    input  logic [31:0] ImemRspData,
    output logic [31:0] Pc_IF,
    output logic [31:0] FetchData_IF,
    output logic        InstrVal_IF,
    output logic [31:0] BubbleCnt,
    output logic [31:0] DropCnt
);
    localparam int            AW      = $clog2(BUF_DEPTH);
    localparam int            CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(BUF_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_pend;
    logic [CW-1:0] fifo_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   pc_mem   [BUF_DEPTH];
    logic [31:0]   data_mem [BUF_DEPTH];

    logic        jump_take;
    logic        redirect;
    logic [3:0]  jump_seg;
    logic [31:0] redirect_pc;
    logic        grant;
    logic        rsp_ok;
    logic        drop_rsp;
    logic        push;
    logic        pop;

    // Segment bits of Pc_IF+4: bit 28 carries in only when PC[27:2] is all ones.
    assign jump_seg    = Pc_IF[31:28] + 4'(Pc_IF[27:2] == '1);
    assign jump_take   = Jump_IDM1 && InstrVal_IF && !AnyStall;
    assign redirect    = ExRedirect_EX || jump_take;
    assign redirect_pc = ExRedirect_EX ? ExRedirectPc_EX : {jump_seg, JumpTgt_IDM1, 2'b00};

    assign ImemReq  = !reset && !redirect && (({1'b0, outstanding} + {1'b0, fifo_cnt}) < DEPTH_C);
    assign ImemAddr = fetch_pc;
    assign grant    = ImemReq && ImemGnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok   = ImemRspVal && (outstanding != '0);
    assign drop_rsp = rsp_ok && (redirect || (drop_pend != '0));
    assign push     = rsp_ok && !drop_rsp;
    assign pop      = !redirect && !AnyStall && (fifo_cnt != '0);

    // Request side: fetch PC, outstanding credit and stale-response count.
    // Every request in flight at a redirect is stale, so drop_pend simply
    // becomes what stays outstanding after this cycle's response.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_pend   <= '0;
        end else begin
            if (redirect)
                fetch_pc <= redirect_pc;
            else if (grant)
                fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CW'(grant) - CW'(rsp_ok);
            if (redirect)
                drop_pend <= outstanding - CW'(rsp_ok);
            else if (drop_rsp)
                drop_pend <= drop_pend - CW'(1);
        end
    end

    // PC tag of the next kept response: kept responses are exactly the
    // requests issued since the last redirect, in order, so a running PC
    // reproduces the address at issue without a per-request tag queue.
    always_ff @(posedge clk) begin
        if (reset)
            rsp_pc <= RESET_PC;
        else if (redirect)
            rsp_pc <= redirect_pc;
        else if (push)
            rsp_pc <= rsp_pc + 32'd4;
    end

    // FIFO pointers and occupancy; a redirect flushes everything buffered.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are qualified by fifo_cnt so need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            data_mem[wr_ptr] <= ImemRspData;
        end
    end

    // IF output register: invalidate on redirect, hold on stall, else load head.
    always_ff @(posedge clk) begin
        if (reset) begin
            Pc_IF        <= '0;
            FetchData_IF <= '0;
            InstrVal_IF  <= 1'b0;
        end else if (redirect) begin
            InstrVal_IF <= 1'b0;
        end else if (!AnyStall) begin
            InstrVal_IF <= pop;
            if (pop) begin
                Pc_IF        <= pc_mem[rd_ptr];
                FetchData_IF <= data_mem[rd_ptr];
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_q;
    logic [31:0] drop_q;

    // Perf counters: decode-visible bubbles and discarded responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_q <= '0;
            drop_q   <= '0;
        end else begin
            if (!AnyStall && !InstrVal_IF)
                bubble_q <= bubble_q + 32'd1;
            if (drop_rsp)
                drop_q <= drop_q + 32'd1;
        end
    end

    assign BubbleCnt = bubble_q;
    assign DropCnt   = drop_q;
`else
    assign BubbleCnt = '0;
    assign DropCnt   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-programmable
// in-order instruction memory model (data word = ~address).
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        AnyStall;
    logic        Jump_IDM1;
    logic [25:0] JumpTgt_IDM1;
    logic        ExRedirect_EX;
    logic [31:0] ExRedirectPc_EX;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt = 1'b0;
    logic        ImemRspVal = 1'b0;
    logic [31:0] ImemRspData = '0;
    logic [31:0] Pc_IF;
    logic [31:0] FetchData_IF;
    logic        InstrVal_IF;
    logic [31:0] BubbleCnt;
    logic [31:0] DropCnt;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .AnyStall(AnyStall),
        .Jump_IDM1(Jump_IDM1), .JumpTgt_IDM1(JumpTgt_IDM1),
        .ExRedirect_EX(ExRedirect_EX), .ExRedirectPc_EX(ExRedirectPc_EX),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRspVal(ImemRspVal), .ImemRspData(ImemRspData),
        .Pc_IF(Pc_IF), .FetchData_IF(FetchData_IF), .InstrVal_IF(InstrVal_IF),
        .BubbleCnt(BubbleCnt), .DropCnt(DropCnt)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    // Memory model: grant per gmode (0 always, 1 toggling, 2 never),
    // response lat cycles after the grant cycle, in order.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t q[$];
    int cyc   = 0;
    int lat   = 1;
    int gmode = 0;
    int maxq  = 0;

    always begin
        @(negedge clk);
        cyc++;
        if (reset === 1'b1) q.delete();
        ImemRspVal  = 1'b0;
        ImemRspData = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ImemRspVal  = 1'b1;
            ImemRspData = ~q[0].addr;
            void'(q.pop_front());
        end
        #2;
        ImemGnt = (gmode == 0) || (gmode == 1 && cyc[0]);
        #2;
        if (reset === 1'b0 && ImemReq && ImemGnt) begin
            q.push_back('{ImemAddr, cyc + lat});
            if (q.size() > maxq) maxq = q.size();
        end
    end

    // One cycle: inputs change at negedge+1, registered outputs stable.
    task automatic tick();
        @(negedge clk);
        Jump_IDM1     = 1'b0;
        ExRedirect_EX = 1'b0;
        #1;
    endtask

    // Returns in cycle 0 (first cycle with reset low).
    task automatic rst(input int l, input int g);
        reset = 1'b1;
        AnyStall = 1'b0;
        lat = l;
        gmode = g;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc);
        int n = 0;
        tick();
        while (!InstrVal_IF && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_v"}, 32'(InstrVal_IF), 32'd1);
        chk({tag, "_pc"}, Pc_IF, pc);
        chk({tag, "_dat"}, FetchData_IF, ~pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [31:0] drop0;

    initial begin
        reset = 1'b1; AnyStall = 1'b0; Jump_IDM1 = 1'b0; JumpTgt_IDM1 = '0;
        ExRedirect_EX = 1'b0; ExRedirectPc_EX = '0;
        repeat (3) tick();
        #1;
        chk("rst_req", 32'(ImemReq), 32'd0);
        chk("rst_val", 32'(InstrVal_IF), 32'd0);
        chk("rst_pc", Pc_IF, 32'd0);
        chk("rst_dat", FetchData_IF, 32'd0);
        chk("rst_bub", BubbleCnt, 32'd0);
        chk("rst_drop", DropCnt, 32'd0);

        // Zero-wait memory, L=1
        tick(); reset = 1'b0; #1;
        chk("c0_req", 32'(ImemReq), 32'd1);
        chk("c0_addr", ImemAddr, 32'h100);
        tick(); #1;
        chk("c1_addr", ImemAddr, 32'h104);
        chk("c1_val", 32'(InstrVal_IF), 32'd0);
        tick();
        chk("c2_val", 32'(InstrVal_IF), 32'd0);
        tick();
        chk("c3_val", 32'(InstrVal_IF), 32'd1);
        chk("c3_pc", Pc_IF, 32'h100);
        chk("c3_dat", FetchData_IF, ~32'h100);
        chk("c3_bub", BubbleCnt, PERF ? 32'd3 : 32'd0);
        tick();
        chk("c4_pc", Pc_IF, 32'h104);

        // Stall three cycles while 0x108 is presented
        tick();
        chk("c5_pc", Pc_IF, 32'h108);
        AnyStall = 1'b1;
        tick();
        chk("st1_pc", Pc_IF, 32'h108);
        tick(); #1;
        chk("st2_pc", Pc_IF, 32'h108);
        chk("st2_req", 32'(ImemReq), 32'd0);
        tick();
        AnyStall = 1'b0; #1;
        chk("st3_pc", Pc_IF, 32'h108);
        chk("st3_dat", FetchData_IF, ~32'h108);
        chk("st3_req", 32'(ImemReq), 32'd0);
        tick();
        chk("res_pc", Pc_IF, 32'h10C);
        chk("res_v", 32'(InstrVal_IF), 32'd1);
        tick();
        chk("res2_pc", Pc_IF, 32'h110);

        // EX redirect then J, L=2 (two responses in flight)
        rst(2, 0);
        repeat (8) tick();
        ExRedirect_EX = 1'b1; ExRedirectPc_EX = 32'h0040_0000;
        for (int i = 0; i < 5; i++)
            wait_valid("exr", 32'h0040_0000 + 32'(4 * i));
        drop0 = DropCnt;
        Jump_IDM1 = 1'b1; JumpTgt_IDM1 = 26'h0000100; #1;
        chk("j_req", 32'(ImemReq), 32'd0);
        tick();
        chk("j_addr", ImemAddr, 32'h0000_0400);
        chk("j_req1", 32'(ImemReq), 32'd1);
        chk("j_val", 32'(InstrVal_IF), 32'd0);
        wait_valid("j0", 32'h400);
        wait_valid("j1", 32'h404);
        chk("j_drop", DropCnt - drop0, PERF ? 32'd2 : 32'd0);

        // EX redirect wins over a simultaneous jump
        ExRedirect_EX = 1'b1; ExRedirectPc_EX = 32'h200;
        Jump_IDM1 = 1'b1; JumpTgt_IDM1 = 26'h3FF_FFFF;
        tick();
        chk("pri_addr", ImemAddr, 32'h200);
        wait_valid("pri0", 32'h200);
        wait_valid("pri1", 32'h204);

        // L=3 with toggling grant: order and credit limit
        rst(3, 1);
        maxq = 0;
        for (int i = 0; i < 12; i++)
            wait_valid("tg", 32'h100 + 32'(4 * i));
        chk("tg_credit", 32'(maxq <= 4), 32'd1);

        // Redirect with exactly three outstanding
        rst(6, 0);
        tick(); tick(); tick();
        gmode = 2;
        tick();
        ExRedirect_EX = 1'b1; ExRedirectPc_EX = 32'h800; #1;
        chk("d3_req", 32'(ImemReq), 32'd0);
        tick();
        chk("d3_addr", ImemAddr, 32'h800);
        repeat (4) tick();
        gmode = 0;
        wait_valid("d3", 32'h800);
        chk("d3_cnt", DropCnt, PERF ? 32'd3 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
